// File: rtl/ni_inject_fifo.sv
// Injection FIFO between a core and the routing stage: buffers flits and drops
// any flit that breaks header/body/tail framing, flagging it on a sticky error bit.
module ni_inject_fifo #(
    parameter int FLIT_SIZE      = 64,
    parameter int FLIT_TYPE_SIZE = 2,
    parameter int DEPTH          = 8,
    // Type encodings; bit 1 marks a packet start, bit 0 a packet end.
    parameter logic [FLIT_TYPE_SIZE-1:0] TYPE_BODY        = FLIT_TYPE_SIZE'(0),
    parameter logic [FLIT_TYPE_SIZE-1:0] TYPE_TAIL        = FLIT_TYPE_SIZE'(1),
    parameter logic [FLIT_TYPE_SIZE-1:0] TYPE_HEADER      = FLIT_TYPE_SIZE'(2),
    parameter logic [FLIT_TYPE_SIZE-1:0] TYPE_HEADER_TAIL = FLIT_TYPE_SIZE'(3)
) (
    input  logic                      clk,
    input  logic                      rst_p,
    input  logic                      ValidIn,
    input  logic [FLIT_SIZE-1:0]      FlitIn,
    input  logic [FLIT_TYPE_SIZE-1:0] FlitTypeIn,
    input  logic                      BroadcastFlitIn,
    output logic                      ReadyOut,
    input  logic                      Avail,
    output logic                      Req,
    output logic [FLIT_SIZE-1:0]      Flit,
    output logic [FLIT_TYPE_SIZE-1:0] FlitType,
    output logic                      BroadcastFlit,
    output logic [$clog2(DEPTH):0]    Occupancy,
    output logic                      ProtoErr
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = FLIT_SIZE + FLIT_TYPE_SIZE + 1;

    typedef enum logic {
        OUT_PKT = 1'b0,
        IN_PKT  = 1'b1
    } frame_state_t;

    frame_state_t     state_reg;
    logic             proto_err_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head_entry;

    logic handshake;
    logic type_ok;
    logic push;
    logic pop;

    // Flow control depends only on registered state so neither side sees a
    // combinational path through the other.
    assign ReadyOut  = (count_reg != CNT_W'(DEPTH));
    assign Req       = (count_reg != '0) && Avail;
    assign Occupancy = count_reg;
    assign ProtoErr  = proto_err_reg;

    assign handshake = ValidIn && ReadyOut;
    assign push      = handshake && type_ok;
    assign pop       = Req;

    always_comb begin
        type_ok = 1'b0;
        case (state_reg)
            OUT_PKT: type_ok = (FlitTypeIn == TYPE_HEADER) ||
                               (FlitTypeIn == TYPE_HEADER_TAIL);
            IN_PKT:  type_ok = (FlitTypeIn == TYPE_BODY) ||
                               (FlitTypeIn == TYPE_TAIL);
            default: type_ok = 1'b0;
        endcase
    end

    // Framing FSM; a rejected flit is still consumed so the core never stalls.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            state_reg     <= OUT_PKT;
            proto_err_reg <= 1'b0;
        end else if (handshake) begin
            case (state_reg)
                OUT_PKT: begin
                    if (FlitTypeIn == TYPE_HEADER) begin
                        state_reg <= IN_PKT;
                    end else if (FlitTypeIn != TYPE_HEADER_TAIL) begin
                        proto_err_reg <= 1'b1;
                    end
                end
                IN_PKT: begin
                    if (FlitTypeIn == TYPE_TAIL) begin
                        state_reg <= OUT_PKT;
                    end else if (FlitTypeIn != TYPE_BODY) begin
                        proto_err_reg <= 1'b1;
                    end
                end
                default: state_reg <= OUT_PKT;
            endcase
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    assign wr_entry = {BroadcastFlitIn, FlitTypeIn, FlitIn};

    // Storage is deliberately not reset; the count alone says what is valid.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem[gi] <= wr_entry;
                end
            end
        end
    endgenerate

    // The head is read asynchronously, so a write only appears a cycle later.
    assign head_entry    = mem[rd_ptr_reg];
    assign Flit          = head_entry[FLIT_SIZE-1:0];
    assign FlitType      = head_entry[FLIT_SIZE +: FLIT_TYPE_SIZE];
    assign BroadcastFlit = head_entry[ENTRY_W-1];

endmodule

// File: tb/tb_ni_inject_fifo.sv
// Directed bench for ni_inject_fifo: framing, full/empty edges, pointer wrap and reset.
module tb_ni_inject_fifo;

    localparam logic [1:0] BODY = 2'd0;
    localparam logic [1:0] TAIL = 2'd1;
    localparam logic [1:0] HDR  = 2'd2;
    localparam logic [1:0] HT   = 2'd3;

    logic        clk = 1'b0;
    logic        rst_p;
    logic        valid_in;
    logic [63:0] flit_in;
    logic [1:0]  type_in;
    logic        bc_in;
    logic        avail;
    logic        ready_out;
    logic        req;
    logic [63:0] flit;
    logic [1:0]  ftype;
    logic        bc;
    logic [3:0]  occ;
    logic        proto_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ni_inject_fifo #(
        .FLIT_SIZE(64), .FLIT_TYPE_SIZE(2), .DEPTH(8),
        .TYPE_BODY(BODY), .TYPE_TAIL(TAIL), .TYPE_HEADER(HDR), .TYPE_HEADER_TAIL(HT)
    ) dut (
        .clk(clk), .rst_p(rst_p),
        .ValidIn(valid_in), .FlitIn(flit_in), .FlitTypeIn(type_in),
        .BroadcastFlitIn(bc_in), .ReadyOut(ready_out),
        .Avail(avail), .Req(req), .Flit(flit), .FlitType(ftype),
        .BroadcastFlit(bc), .Occupancy(occ), .ProtoErr(proto_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Apply inputs mid-cycle and let combinational outputs settle.
    task automatic drive(input logic v, input logic [1:0] t, input logic [63:0] f,
                         input logic b, input logic a);
        valid_in = v;
        type_in  = t;
        flit_in  = f;
        bc_in    = b;
        avail    = a;
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        #3 rst_p = 1'b1;
        @(posedge clk);
        #1 rst_p = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_p = 1'b1;
        drive(0, BODY, 0, 0, 1);
        #1;
        check("rst_req", req, 0);
        check("rst_ready", ready_out, 1);
        check("rst_occ", occ, 0);
        check("rst_perr", proto_err, 0);
        @(posedge clk);
        #1 rst_p = 1'b0;

        // Header/body/tail streaming through with Avail high
        drive(1, HDR, 64'hA, 0, 1);
        check("p1_empty_req", req, 0);
        cyc();
        drive(1, BODY, 64'hB, 0, 1);
        check("p1_req_a", req, 1);
        check("p1_flit_a", flit, 64'hA);
        check("p1_type_a", ftype, HDR);
        cyc();
        drive(1, TAIL, 64'hC, 1, 1);
        check("p1_occ_mid", occ, 1);
        check("p1_flit_b", flit, 64'hB);
        cyc();
        drive(0, BODY, 0, 0, 1);
        check("p1_req_c", req, 1);
        check("p1_flit_c", flit, 64'hC);
        check("p1_type_c", ftype, TAIL);
        check("p1_bc_c", bc, 1);
        cyc();
        drive(0, BODY, 0, 0, 0);
        check("p1_occ_end", occ, 0);
        check("p1_req_end", req, 0);
        check("p1_perr", proto_err, 0);

        // Fill to DEPTH, reject a 9th, then pop one
        for (int i = 0; i < 8; i++) begin
            drive(1, HT, 64'(100 + i), 0, 0);
            cyc();
        end
        drive(1, HT, 64'h999, 0, 0);
        check("full_occ", occ, 8);
        check("full_ready", ready_out, 0);
        cyc();
        drive(1, HT, 64'h999, 0, 1);
        check("full_no_push", occ, 8);
        check("full_pop_req", req, 1);
        check("full_pop_flit", flit, 64'd100);
        check("full_pop_ready", ready_out, 0);
        cyc();
        drive(0, BODY, 0, 0, 0);
        check("after_pop_occ", occ, 7);
        check("after_pop_ready", ready_out, 1);
        for (int i = 1; i < 8; i++) begin
            drive(0, BODY, 0, 0, 1);
            check("drain_full", flit, 64'(100 + i));
            cyc();
        end
        drive(0, BODY, 0, 0, 0);
        check("drain_full_occ", occ, 0);

        // Occupancy 3 with concurrent push/pop across the pointer wrap
        for (int i = 0; i < 6; i++) begin
            drive(1, HT, 64'(300 + i), 0, 0);
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, BODY, 0, 0, 1);
            check("wrap_pre_pop", flit, 64'(300 + i));
            cyc();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, HT, 64'(310 + i), 0, 1);
            check("wrap_occ", occ, 3);
            check("wrap_req", req, 1);
            check("wrap_flit", flit, (i < 3) ? 64'(303 + i) : 64'd310);
            cyc();
        end
        drive(0, BODY, 0, 0, 0);
        check("wrap_occ_after", occ, 3);
        for (int i = 0; i < 3; i++) begin
            drive(0, BODY, 0, 0, 1);
            check("wrap_drain", flit, 64'(311 + i));
            cyc();
        end
        drive(0, BODY, 0, 0, 0);
        check("wrap_occ_end", occ, 0);

        // Body while outside a packet is consumed but dropped
        drive(1, BODY, 64'h55, 0, 0);
        check("drop_ready", ready_out, 1);
        cyc();
        drive(0, BODY, 0, 0, 0);
        check("drop_occ", occ, 0);
        check("drop_perr", proto_err, 1);
        drive(1, HT, 64'hD0, 0, 0);
        cyc();
        drive(0, BODY, 0, 0, 1);
        check("legal_after_req", req, 1);
        check("legal_after_flit", flit, 64'hD0);
        check("perr_sticky", proto_err, 1);
        cyc();
        drive(0, BODY, 0, 0, 0);
        check("legal_after_occ", occ, 0);

        // Header inside a packet is dropped; tail still closes the packet
        async_reset();
        drive(0, BODY, 0, 0, 0);
        check("rst2_perr", proto_err, 0);
        drive(1, HDR, 64'hE0, 0, 0);
        cyc();
        drive(1, HDR, 64'hF0, 0, 0);
        cyc();
        drive(1, TAIL, 64'hC0, 0, 0);
        cyc();
        drive(1, HT, 64'hA0, 0, 0);
        check("inpkt_occ", occ, 2);
        check("inpkt_perr", proto_err, 1);
        cyc();
        drive(0, BODY, 0, 0, 0);
        check("inpkt_ht_accepted", occ, 3);
        drive(0, BODY, 0, 0, 1);
        check("inpkt_flit0", flit, 64'hE0);
        check("inpkt_type0", ftype, HDR);
        cyc();
        check("inpkt_flit1", flit, 64'hC0);
        check("inpkt_type1", ftype, TAIL);
        cyc();
        check("inpkt_flit2", flit, 64'hA0);
        check("inpkt_type2", ftype, HT);
        cyc();
        drive(0, BODY, 0, 0, 0);
        check("inpkt_occ_end", occ, 0);

        // Asynchronous reset mid-packet with 5 flits stored
        drive(1, HDR, 64'h40, 0, 0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            drive(1, BODY, 64'(64'h41 + i), 0, 0);
            cyc();
        end
        drive(0, BODY, 0, 0, 1);
        check("pre_rst_occ", occ, 5);
        check("pre_rst_req", req, 1);
        #3 rst_p = 1'b1;
        #1;
        check("arst_req", req, 0);
        check("arst_occ", occ, 0);
        check("arst_ready", ready_out, 1);
        @(posedge clk);
        #1 rst_p = 1'b0;
        drive(1, BODY, 64'h50, 0, 0);
        check("post_rst_perr0", proto_err, 0);
        cyc();
        drive(0, BODY, 0, 0, 0);
        check("post_rst_body_occ", occ, 0);
        check("post_rst_body_perr", proto_err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
